// File: rtl/feature_ram_ctrl.sv
// Feature RAM / weight ROM sequencer for the ShuffleNet core.
// Loads MFSC frames into bank A, then ping-pongs banks per stage during inference.
module feature_ram_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WADDR_W = 12
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               mfsc_valid,
    input  logic               MFSC_Ready,
    input  logic [5:0]         next_Stage,
    input  logic [6:0]         next_Kernel_Cnt,
    input  logic               Input_Require_WP,
    input  logic               Write_Require,
    input  logic               Kernel_Require,
    input  logic               Result_Ready,
    output logic               ramA_en,
    output logic               ramA_we,
    output logic [ADDR_W-1:0]  ramA_addr,
    output logic               ramB_en,
    output logic               ramB_we,
    output logic [ADDR_W-1:0]  ramB_addr,
    output logic               ramA_wsel,
    output logic               inA_sel,
    output logic               w_en,
    output logic [WADDR_W-1:0] w_addr,
    output logic               busy,
    output logic               ovf_err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic                src_bank_q, src_bank_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WADDR_W-1:0]  w_ptr_q, w_ptr_d;
    logic [5:0]          cur_stage_q, cur_stage_d;
    logic [6:0]          cur_kcnt_q, cur_kcnt_d;

    logic                ramA_en_q, ramA_en_d, ramA_we_q, ramA_we_d;
    logic [ADDR_W-1:0]   ramA_addr_q, ramA_addr_d;
    logic                ramB_en_q, ramB_en_d, ramB_we_q, ramB_we_d;
    logic [ADDR_W-1:0]   ramB_addr_q, ramB_addr_d;
    logic                ramA_wsel_q, ramA_wsel_d;
    logic                inA_sel_q, inA_sel_d;
    logic                w_en_q, w_en_d;
    logic [WADDR_W-1:0]  w_addr_q, w_addr_d;
    logic                busy_q, busy_d;
    logic                ovf_err_q, ovf_err_d;

    logic                stage_chg, kern_chg, src;
    logic [ADDR_W-1:0]   rd_base, wr_base;

    always_comb begin
        state_d     = state_q;
        src_bank_d  = src_bank_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        w_ptr_d     = w_ptr_q;
        cur_stage_d = cur_stage_q;
        cur_kcnt_d  = cur_kcnt_q;
        ramA_en_d   = 1'b0;
        ramA_we_d   = 1'b0;
        ramA_addr_d = ramA_addr_q;
        ramB_en_d   = 1'b0;
        ramB_we_d   = 1'b0;
        ramB_addr_d = ramB_addr_q;
        ramA_wsel_d = ramA_wsel_q;
        inA_sel_d   = inA_sel_q;
        w_en_d      = 1'b0;
        w_addr_d    = w_addr_q;
        ovf_err_d   = ovf_err_q;
        stage_chg   = 1'b0;
        kern_chg    = 1'b0;
        src         = src_bank_q;
        rd_base     = rd_ptr_q;
        wr_base     = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (mfsc_valid) begin
                    state_d     = LOAD;
                    ovf_err_d   = 1'b0;
                    ramA_en_d   = 1'b1;
                    ramA_we_d   = 1'b1;
                    ramA_addr_d = '0;
                    ramA_wsel_d = 1'b0;
                    inA_sel_d   = 1'b0;
                    wr_ptr_d    = ADDR_W'(1);
                end
            end
            LOAD: begin
                ramA_wsel_d = 1'b0;
                if (mfsc_valid) begin
                    ramA_en_d   = 1'b1;
                    ramA_we_d   = 1'b1;
                    ramA_addr_d = wr_ptr_q;
                    wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                    if (wr_ptr_q == '1) ovf_err_d = 1'b1;
                end
                if (MFSC_Ready) begin
                    state_d     = RUN;
                    src_bank_d  = 1'b0;
                    inA_sel_d   = 1'b0;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    w_ptr_d     = '0;
                    cur_stage_d = next_Stage;
                    cur_kcnt_d  = next_Kernel_Cnt;
                end
            end
            RUN: begin
                if (Result_Ready) begin
                    state_d = DONE;
                end else begin
                    // Boundaries rebase the pointers before this cycle's strobes use them.
                    stage_chg   = (next_Stage != cur_stage_q);
                    kern_chg    = !stage_chg && (next_Kernel_Cnt != cur_kcnt_q);
                    src         = stage_chg ? ~src_bank_q : src_bank_q;
                    rd_base     = (stage_chg || kern_chg) ? '0 : rd_ptr_q;
                    wr_base     = stage_chg ? '0 : wr_ptr_q;
                    src_bank_d  = src;
                    rd_ptr_d    = rd_base;
                    wr_ptr_d    = wr_base;
                    cur_stage_d = next_Stage;
                    cur_kcnt_d  = next_Kernel_Cnt;
                    inA_sel_d   = src;
                    ramA_wsel_d = 1'b1;

                    if (Input_Require_WP) begin
                        if (!src) begin
                            ramA_en_d   = 1'b1;
                            ramA_addr_d = rd_base;
                        end else begin
                            ramB_en_d   = 1'b1;
                            ramB_addr_d = rd_base;
                        end
                        rd_ptr_d = rd_base + ADDR_W'(1);
                        if (rd_base == '1) ovf_err_d = 1'b1;
                    end
                    if (Write_Require) begin
                        if (src) begin
                            ramA_en_d   = 1'b1;
                            ramA_we_d   = 1'b1;
                            ramA_addr_d = wr_base;
                        end else begin
                            ramB_en_d   = 1'b1;
                            ramB_we_d   = 1'b1;
                            ramB_addr_d = wr_base;
                        end
                        wr_ptr_d = wr_base + ADDR_W'(1);
                        if (wr_base == '1) ovf_err_d = 1'b1;
                    end
                    if (Kernel_Require) begin
                        w_en_d   = 1'b1;
                        w_addr_d = w_ptr_q;
                        w_ptr_d  = w_ptr_q + WADDR_W'(1);
                        if (w_ptr_q == '1) ovf_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!MFSC_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == LOAD) || (state_d == RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            src_bank_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            w_ptr_q     <= '0;
            cur_stage_q <= '0;
            cur_kcnt_q  <= '0;
            ramA_en_q   <= 1'b0;
            ramA_we_q   <= 1'b0;
            ramA_addr_q <= '0;
            ramB_en_q   <= 1'b0;
            ramB_we_q   <= 1'b0;
            ramB_addr_q <= '0;
            ramA_wsel_q <= 1'b0;
            inA_sel_q   <= 1'b0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            busy_q      <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_bank_q  <= src_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            w_ptr_q     <= w_ptr_d;
            cur_stage_q <= cur_stage_d;
            cur_kcnt_q  <= cur_kcnt_d;
            ramA_en_q   <= ramA_en_d;
            ramA_we_q   <= ramA_we_d;
            ramA_addr_q <= ramA_addr_d;
            ramB_en_q   <= ramB_en_d;
            ramB_we_q   <= ramB_we_d;
            ramB_addr_q <= ramB_addr_d;
            ramA_wsel_q <= ramA_wsel_d;
            inA_sel_q   <= inA_sel_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            busy_q      <= busy_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign ramA_en   = ramA_en_q;
    assign ramA_we   = ramA_we_q;
    assign ramA_addr = ramA_addr_q;
    assign ramB_en   = ramB_en_q;
    assign ramB_we   = ramB_we_q;
    assign ramB_addr = ramB_addr_q;
    assign ramA_wsel = ramA_wsel_q;
    assign inA_sel   = inA_sel_q;
    assign w_en      = w_en_q;
    assign w_addr    = w_addr_q;
    assign busy      = busy_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_feature_ram_ctrl.sv
// Directed bench for feature_ram_ctrl; a second ADDR_W=2 instance covers pointer wrap.
module tb_feature_ram_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        mfsc_valid, MFSC_Ready;
    logic [5:0]  next_Stage;
    logic [6:0]  next_Kernel_Cnt;
    logic        Input_Require_WP, Write_Require, Kernel_Require, Result_Ready;

    logic        ramA_en, ramA_we, ramB_en, ramB_we, ramA_wsel, inA_sel, w_en, busy, ovf_err;
    logic [9:0]  ramA_addr, ramB_addr;
    logic [11:0] w_addr;

    logic        s_ramA_en, s_ramA_we, s_ramB_en, s_ramB_we, s_ramA_wsel, s_inA_sel, s_w_en, s_busy, s_ovf_err;
    logic [1:0]  s_ramA_addr, s_ramB_addr;
    logic [11:0] s_w_addr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    feature_ram_ctrl #(.ADDR_W(10), .WADDR_W(12)) dut (
        .CLK(CLK), .RST_N(RST_N), .mfsc_valid(mfsc_valid), .MFSC_Ready(MFSC_Ready),
        .next_Stage(next_Stage), .next_Kernel_Cnt(next_Kernel_Cnt),
        .Input_Require_WP(Input_Require_WP), .Write_Require(Write_Require),
        .Kernel_Require(Kernel_Require), .Result_Ready(Result_Ready),
        .ramA_en(ramA_en), .ramA_we(ramA_we), .ramA_addr(ramA_addr),
        .ramB_en(ramB_en), .ramB_we(ramB_we), .ramB_addr(ramB_addr),
        .ramA_wsel(ramA_wsel), .inA_sel(inA_sel), .w_en(w_en), .w_addr(w_addr),
        .busy(busy), .ovf_err(ovf_err)
    );

    feature_ram_ctrl #(.ADDR_W(2), .WADDR_W(12)) dut_small (
        .CLK(CLK), .RST_N(RST_N), .mfsc_valid(mfsc_valid), .MFSC_Ready(MFSC_Ready),
        .next_Stage(next_Stage), .next_Kernel_Cnt(next_Kernel_Cnt),
        .Input_Require_WP(Input_Require_WP), .Write_Require(Write_Require),
        .Kernel_Require(Kernel_Require), .Result_Ready(Result_Ready),
        .ramA_en(s_ramA_en), .ramA_we(s_ramA_we), .ramA_addr(s_ramA_addr),
        .ramB_en(s_ramB_en), .ramB_we(s_ramB_we), .ramB_addr(s_ramB_addr),
        .ramA_wsel(s_ramA_wsel), .inA_sel(s_inA_sel), .w_en(s_w_en), .w_addr(s_w_addr),
        .busy(s_busy), .ovf_err(s_ovf_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_banks(input string tag,
                               input logic a_en, input logic a_we, input int a_addr,
                               input logic b_en, input logic b_we, input int b_addr);
        check({tag, ".ramA_en"}, 32'(ramA_en), 32'(a_en));
        check({tag, ".ramB_en"}, 32'(ramB_en), 32'(b_en));
        if (a_en) begin
            check({tag, ".ramA_we"}, 32'(ramA_we), 32'(a_we));
            check({tag, ".ramA_addr"}, 32'(ramA_addr), 32'(a_addr));
        end
        if (b_en) begin
            check({tag, ".ramB_we"}, 32'(ramB_we), 32'(b_we));
            check({tag, ".ramB_addr"}, 32'(ramB_addr), 32'(b_addr));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        Input_Require_WP = 1'b0;
        Write_Require    = 1'b0;
        Kernel_Require   = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        mfsc_valid = 1'b0; MFSC_Ready = 1'b0; Result_Ready = 1'b0;
        next_Stage = '0; next_Kernel_Cnt = '0;
        clear_req();
        #23;
        check("rst.ramA_en", 32'(ramA_en), 0);
        check("rst.ramA_addr", 32'(ramA_addr), 0);
        check("rst.w_en", 32'(w_en), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.ovf_err", 32'(ovf_err), 0);
        RST_N = 1'b1;
        step();

        // Load four MFSC words into bank A
        for (int i = 0; i < 4; i++) begin
            mfsc_valid = 1'b1;
            step();
            check_banks($sformatf("load%0d", i), 1, 1, i, 0, 0, 0);
            check($sformatf("load%0d.wsel", i), 32'(ramA_wsel), 0);
            check($sformatf("load%0d.busy", i), 32'(busy), 1);
        end
        mfsc_valid = 1'b0;
        MFSC_Ready = 1'b1;
        step();
        check("run_entry.busy", 32'(busy), 1);
        check("run_entry.inA_sel", 32'(inA_sel), 0);
        check("run_entry.ramA_en", 32'(ramA_en), 0);

        // Stage 0: reads from A, writes to B
        Input_Require_WP = 1'b1;
        step();
        check_banks("s0c0", 1, 0, 0, 0, 0, 0);
        Write_Require = 1'b1;
        step();
        check_banks("s0c1", 1, 0, 1, 1, 1, 0);
        step();
        check_banks("s0c2", 1, 0, 2, 1, 1, 1);
        clear_req();
        step();
        check_banks("s0idle", 0, 0, 0, 0, 0, 0);

        // Stage change with simultaneous read
        next_Stage = 6'd1;
        Input_Require_WP = 1'b1;
        step();
        check("s1.inA_sel", 32'(inA_sel), 1);
        check_banks("s1rd", 0, 0, 0, 1, 0, 0);
        clear_req();
        Write_Require = 1'b1;
        step();
        check_banks("s1wr", 1, 1, 0, 0, 0, 0);
        check("s1wr.wsel", 32'(ramA_wsel), 1);

        // Four more reads (total 5) and one more write (total 2)
        Input_Require_WP = 1'b1;
        Write_Require = 1'b1;
        step();
        check_banks("k0c0", 1, 1, 1, 1, 0, 1);
        Write_Require = 1'b0;
        step();
        check_banks("k0c1", 0, 0, 0, 1, 0, 2);
        step();
        check_banks("k0c2", 0, 0, 0, 1, 0, 3);
        Kernel_Require = 1'b1;
        step();
        check_banks("k0c3", 0, 0, 0, 1, 0, 4);
        check("k0c3.w_en", 32'(w_en), 1);
        check("k0c3.w_addr", 32'(w_addr), 0);

        // Kernel change: read restarts, write continues, weights continue
        next_Kernel_Cnt = 7'd1;
        Write_Require = 1'b1;
        step();
        check_banks("k1c0", 1, 1, 2, 1, 0, 0);
        check("k1c0.w_addr", 32'(w_addr), 1);
        Write_Require = 1'b0;
        step();
        check_banks("k1c1", 0, 0, 0, 1, 0, 1);
        check("k1c1.w_addr", 32'(w_addr), 2);

        // Result_Ready wins over strobes
        Result_Ready = 1'b1;
        step();
        check_banks("done", 0, 0, 0, 0, 0, 0);
        check("done.w_en", 32'(w_en), 0);
        check("done.busy", 32'(busy), 0);
        clear_req();
        Result_Ready = 1'b0;
        MFSC_Ready = 1'b0;
        step();
        Input_Require_WP = 1'b1;
        step();
        check_banks("idle_req", 0, 0, 0, 0, 0, 0);
        clear_req();

        // Pointer wrap on the 2-bit instance
        mfsc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("wrap%0d.addr", i), 32'(s_ramA_addr), 32'(i % 4));
            check($sformatf("wrap%0d.we", i), 32'(s_ramA_we), 1);
            if (i == 2) check("wrap2.ovf", 32'(s_ovf_err), 0);
            if (i == 4) check("wrap4.ovf", 32'(s_ovf_err), 1);
        end
        check("wide.ovf", 32'(ovf_err), 0);
        mfsc_valid = 1'b0;
        MFSC_Ready = 1'b1;
        step();
        check("wrap_run.ovf", 32'(s_ovf_err), 1);
        Result_Ready = 1'b1;
        step();
        Result_Ready = 1'b0;
        MFSC_Ready = 1'b0;
        step();
        check("wrap_idle.ovf", 32'(s_ovf_err), 1);
        mfsc_valid = 1'b1;
        step();
        check("reload.ovf", 32'(s_ovf_err), 0);
        check("reload.addr", 32'(s_ramA_addr), 0);
        mfsc_valid = 1'b0;

        // Async reset mid-RUN
        next_Stage = '0; next_Kernel_Cnt = '0;
        MFSC_Ready = 1'b1;
        step();
        MFSC_Ready = 1'b0;
        Input_Require_WP = 1'b1; Write_Require = 1'b1; Kernel_Require = 1'b1;
        step();
        check("pre_rst.ramA_en", 32'(ramA_en), 1);
        check("pre_rst.w_en", 32'(w_en), 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst.ramA_en", 32'(ramA_en), 0);
        check("arst.ramB_en", 32'(ramB_en), 0);
        check("arst.w_en", 32'(w_en), 0);
        check("arst.busy", 32'(busy), 0);
        check("arst.ramA_addr", 32'(ramA_addr), 0);
        check("arst.ramB_addr", 32'(ramB_addr), 0);
        check("arst.w_addr", 32'(w_addr), 0);
        check("arst.inA_sel", 32'(inA_sel), 0);
        check("arst.wsel", 32'(ramA_wsel), 0);
        #3;
        RST_N = 1'b1;
        step();
        check_banks("post_rst", 0, 0, 0, 0, 0, 0);
        check("post_rst.w_en", 32'(w_en), 0);
        check("post_rst.busy", 32'(busy), 0);
        clear_req();
        mfsc_valid = 1'b1;
        step();
        check_banks("post_rst_load", 1, 1, 0, 0, 0, 0);
        mfsc_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
